// File: rtl/seg_scan_display_if.sv
// Pin-level bundle between the score logic (master) and the multiplexed
// seven-segment driver (slave); clk and rst stay outside the bundle.
interface seg_scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] hexs;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   LEs;
  logic [DIGITS-1:0]   blink;
  logic                lz_en;
  logic [3:0]          brightness;
  logic [DIGITS-1:0]   AN;
  logic [7:0]          SEGMENT;
  logic                frame_start;

  modport master (
    output hexs, points, LEs, blink, lz_en, brightness,
    input  AN, SEGMENT, frame_start
  );

  modport slave (
    input  hexs, points, LEs, blink, lz_en, brightness,
    output AN, SEGMENT, frame_start
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with frame snapshotting,
// per-digit blink/blank, leading-zero suppression and PWM brightness.
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int SCAN_CYCLES  = 100000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_display_if.slave bus
);

  localparam int DIG_W   = $clog2(DIGITS);
  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(DIGITS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  // Active-low a..g glyph for one hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [3:0]          pwm_cnt_q, pwm_cnt_d;
  logic                load_pending_q, load_pending_d;
  logic [4*DIGITS-1:0] snap_hexs_q, snap_hexs_d;
  logic [DIGITS-1:0]   snap_points_q, snap_points_d;
  logic [DIGITS-1:0]   snap_les_q, snap_les_d;
  logic [DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic                snap_lz_q, snap_lz_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_start_q, frame_start_d;

  logic                dwell_wrap_s, blink_wrap_s, load_s;
  logic                zero_run_s, blank_s;
  logic [DIGITS-1:0]   supp_s;
  logic [3:0]          nib_s;

  // Scan timing, blink timebase, PWM counter and frame snapshot.
  always_comb begin
    dwell_wrap_s = (dwell_q == DWELL_LAST);
    blink_wrap_s = (blink_cnt_q == BLINK_LAST);
    load_s       = load_pending_q | (dwell_wrap_s & (digit_q == DIG_LAST));

    dwell_d = dwell_wrap_s ? '0 : dwell_q + 1'b1;
    if (dwell_wrap_s) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end else begin
      digit_d = digit_q;
    end
    blink_cnt_d   = blink_wrap_s ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap_s;
    pwm_cnt_d     = pwm_cnt_q + 4'd1;
    // Any clocked cycle out of reset performs the pending load.
    load_pending_d = 1'b0;
    frame_start_d  = load_s;

    if (load_s) begin
      snap_hexs_d   = bus.hexs;
      snap_points_d = bus.points;
      snap_les_d    = bus.LEs;
      snap_blink_d  = bus.blink;
      snap_lz_d     = bus.lz_en;
    end else begin
      snap_hexs_d   = snap_hexs_q;
      snap_points_d = snap_points_q;
      snap_les_d    = snap_les_q;
      snap_blink_d  = snap_blink_q;
      snap_lz_d     = snap_lz_q;
    end
  end

  // Per-digit leading-zero mask and nibble of the currently selected digit.
  always_comb begin
    supp_s     = '0;
    zero_run_s = snap_lz_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (snap_hexs_q[4*i +: 4] == 4'h0);
      supp_s[i]  = zero_run_s;
    end
    nib_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        nib_s = snap_hexs_q[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
  end

  // Pin values for the selected digit, registered on the next edge.
  always_comb begin
    an_d    = '1;
    seg_d   = 8'hFF;
    blank_s = snap_les_q[digit_q] | (snap_blink_q[digit_q] & blink_phase_q);
    if (blank_s) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      if (pwm_cnt_q < bus.brightness) begin
        an_d[digit_q] = 1'b0;
      end else begin
        an_d = '1;
      end
      seg_d = {~snap_points_q[digit_q], supp_s[digit_q] ? 7'h7F : hex_glyph(nib_s)};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q        <= '0;
      digit_q        <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      pwm_cnt_q      <= 4'd0;
      load_pending_q <= 1'b1;
      snap_hexs_q    <= '0;
      snap_points_q  <= '0;
      snap_les_q     <= '0;
      snap_blink_q   <= '0;
      snap_lz_q      <= 1'b0;
      an_q           <= '1;
      seg_q          <= 8'hFF;
      frame_start_q  <= 1'b0;
    end else begin
      dwell_q        <= dwell_d;
      digit_q        <= digit_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      pwm_cnt_q      <= pwm_cnt_d;
      load_pending_q <= load_pending_d;
      snap_hexs_q    <= snap_hexs_d;
      snap_points_q  <= snap_points_d;
      snap_les_q     <= snap_les_d;
      snap_blink_q   <= snap_blink_d;
      snap_lz_q      <= snap_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign bus.AN          = an_q;
  assign bus.SEGMENT     = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with 4 digits, 4-cycle dwell and
// 64-cycle blink half-period; e counts rising edges since reset release.
module tb_seg_scan_display;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_display #(
    .DIGITS      (DIGITS),
    .SCAN_CYCLES (4),
    .BLINK_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic apply_reset(input logic [15:0] h, input logic [3:0] p, input logic [3:0] le,
                             input logic [3:0] bl, input logic lz, input logic [3:0] br);
    rst            = 1'b0;
    bus.hexs       = h;
    bus.points     = p;
    bus.LEs        = le;
    bus.blink      = bl;
    bus.lz_en      = lz;
    bus.brightness = br;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.hexs = 16'h1A30; bus.points = 4'hF; bus.LEs = 4'h0; bus.blink = 4'h0;
    bus.lz_en = 1'b0; bus.brightness = 4'd15;
    @(negedge clk);
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL reset_an got %b exp 1111", bus.AN); end
    checks++; if (bus.SEGMENT !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp ff", bus.SEGMENT); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", bus.frame_start); end
  endtask

  task automatic test_scan_decode();
    logic [7:0] seg_tab [4] = '{8'hC0, 8'h30, 8'h88, 8'hF9};
    int d;
    logic [3:0] ea;
    logic ef;
    apply_reset(16'h1A30, 4'b0010, 4'h0, 4'h0, 1'b0, 4'd15);
    for (int e = 1; e <= 32; e++) begin
      step();
      d  = ((e - 1) / 4) % 4;
      ea = (e % 16 == 0) ? 4'hF : an_tab[d];
      ef = (e == 1 || e == 16 || e == 32);
      checks++; if (bus.AN !== ea) begin errors++; $display("FAIL scan_an e=%0d got %b exp %b", e, bus.AN, ea); end
      checks++; if (bus.SEGMENT !== seg_tab[d]) begin errors++; $display("FAIL scan_seg e=%0d got %h exp %h", e, bus.SEGMENT, seg_tab[d]); end
      checks++; if (bus.frame_start !== ef) begin errors++; $display("FAIL scan_fs e=%0d got %b exp %b", e, bus.frame_start, ef); end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] old_tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] new_tab [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};
    logic [7:0] es;
    int d;
    apply_reset(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
    for (int e = 1; e <= 32; e++) begin
      step();
      d  = ((e - 1) / 4) % 4;
      es = (e <= 16) ? old_tab[d] : new_tab[d];
      if (e >= 2) begin
        checks++; if (bus.SEGMENT !== es) begin errors++; $display("FAIL snap_seg e=%0d got %h exp %h", e, bus.SEGMENT, es); end
      end
      if (e == 6) bus.hexs = 16'h5678;
    end
  endtask

  task automatic test_lz();
    int          es [8] = '{3, 7, 11, 14, 19, 23, 27, 30};
    logic [3:0]  ea [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0]  eg [8] = '{8'hC0, 8'h99, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    apply_reset(16'h0040, 4'h0, 4'h0, 4'h0, 1'b1, 4'd15);
    for (int k = 0; k < 8; k++) begin
      run_to(es[k]);
      checks++; if (bus.AN !== ea[k]) begin errors++; $display("FAIL lz_an e=%0d got %b exp %b", es[k], bus.AN, ea[k]); end
      checks++; if (bus.SEGMENT !== eg[k]) begin errors++; $display("FAIL lz_seg e=%0d got %h exp %h", es[k], bus.SEGMENT, eg[k]); end
      if (k == 3) begin
        bus.hexs   = 16'h0000;
        bus.points = 4'b0100;
      end
    end
  endtask

  task automatic test_blink_blank();
    int d, ph;
    logic [3:0] ea;
    logic [7:0] eg;
    apply_reset(16'h0000, 4'h0, 4'b1000, 4'b0001, 1'b0, 4'd15);
    for (int e = 1; e <= 256; e++) begin
      step();
      d  = ((e - 1) / 4) % 4;
      ph = ((e - 1) / 64) % 2;
      if (d == 3 || (d == 0 && ph == 1)) begin
        ea = 4'hF; eg = 8'hFF;
      end else begin
        ea = (e % 16 == 0) ? 4'hF : an_tab[d]; eg = 8'hC0;
      end
      if (e >= 2) begin
        checks++; if (bus.AN !== ea) begin errors++; $display("FAIL blink_an e=%0d got %b exp %b", e, bus.AN, ea); end
        checks++; if (bus.SEGMENT !== eg) begin errors++; $display("FAIL blink_seg e=%0d got %h exp %h", e, bus.SEGMENT, eg); end
      end
    end
  endtask

  task automatic test_brightness();
    int blanks = 0;
    int lit = 0;
    apply_reset(16'h1A30, 4'h0, 4'h0, 4'h0, 1'b0, 4'd4);
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e >= 17 && bus.AN === 4'hF) blanks++;
    end
    checks++; if (blanks !== 12) begin errors++; $display("FAIL bright4_dark got %0d exp 12", blanks); end
    bus.brightness = 4'd0;
    for (int e = 33; e <= 64; e++) begin
      step();
      if (bus.AN !== 4'hF) lit++;
      if (e == 37) begin
        checks++; if (bus.SEGMENT !== 8'hB0) begin errors++; $display("FAIL bright0_seg got %h exp b0", bus.SEGMENT); end
      end
    end
    checks++; if (lit !== 0) begin errors++; $display("FAIL bright0_lit got %0d exp 0", lit); end
  endtask

  task automatic test_async_reset();
    apply_reset(16'h1A30, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
    run_to(10);
    checks++; if (bus.AN !== 4'b1011) begin errors++; $display("FAIL areset_pre_an got %b exp 1011", bus.AN); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL areset_an got %b exp 1111", bus.AN); end
    checks++; if (bus.SEGMENT !== 8'hFF) begin errors++; $display("FAIL areset_seg got %h exp ff", bus.SEGMENT); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL areset_fs got %b exp 0", bus.frame_start); end
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    step();
    checks++; if (bus.AN !== 4'b1110) begin errors++; $display("FAIL arel_an got %b exp 1110", bus.AN); end
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL arel_fs got %b exp 1", bus.frame_start); end
    run_to(5);
    checks++; if (bus.SEGMENT !== 8'hB0) begin errors++; $display("FAIL arel_seg got %h exp b0", bus.SEGMENT); end
  endtask

  initial begin
    test_reset();
    test_scan_decode();
    test_snapshot();
    test_lz();
    test_blink_blank();
    test_brightness();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
